// File: rtl/timer_unit.sv
// DIV/TIMA/TMA/TAC timer block at FF04..FF07 with delayed TIMA reload and interrupt pulse.
// Build option: define TIMER_RELOAD_DELAY_EN for a 4-cycle overflow window before reload (default 1 cycle).
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   ST_IDLE    | counting normally, no overflow outstanding
//   ST_PENDING | TIMA overflowed and reads 00; a CPU write to TIMA cancels
//   ST_RELOAD  | TIMA <= TMA on the closing edge, oTimerIrq high this cycle
module timer_unit (
  input  logic        iClock,
  input  logic        iReset,
  input  logic [15:0] iAddr,
  input  logic [7:0]  iData,
  input  logic        iWe,
  output logic [7:0]  oData,
  output logic        oSelected,
  output logic        oTimerIrq
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_RELOAD  = 2'd2
  } state_t;

  localparam logic [13:0] TIMER_PAGE = 14'h3FC1;  // FF04..FF07 share iAddr[15:2]

  state_t      state;
  state_t      state_next;
  logic [15:0] div;
  logic [7:0]  tima;
  logic [7:0]  tma;
  logic [2:0]  tac;
  logic        tap_hist;
  logic        tap_bit;
  logic        tick_sig;
  logic        tick;
  logic        overflow;
  logic        pend_done;
  logic        wr_div;
  logic        wr_tima;
  logic        wr_tma;
  logic        wr_tac;

  assign oSelected = (iAddr[15:2] == TIMER_PAGE);
  assign wr_div    = iWe && oSelected && (iAddr[1:0] == 2'b00);
  assign wr_tima   = iWe && oSelected && (iAddr[1:0] == 2'b01);
  assign wr_tma    = iWe && oSelected && (iAddr[1:0] == 2'b10);
  assign wr_tac    = iWe && oSelected && (iAddr[1:0] == 2'b11);

  always_comb begin
    tap_bit = 1'b0;
    case (tac[1:0])
      2'b00:   tap_bit = div[9];
      2'b01:   tap_bit = div[3];
      2'b10:   tap_bit = div[5];
      default: tap_bit = div[7];
    endcase
  end

  // A falling edge of the gated tap is a tick, so DIV clears and TAC writes can tick too.
  assign tick_sig = tac[2] & tap_bit;
  assign tick     = tap_hist & ~tick_sig;
  assign overflow = (state == ST_IDLE) && tick && (tima == 8'hFF) && !wr_tima;

`ifdef TIMER_RELOAD_DELAY_EN
  localparam logic [1:0] PEND_LOAD = 2'd3;

  logic [1:0] pend_cnt;

  always_ff @(posedge iClock) begin
    if (iReset) begin
      pend_cnt <= 2'd0;
    end else if (overflow) begin
      pend_cnt <= PEND_LOAD;
    end else if ((state == ST_PENDING) && (pend_cnt != 2'd0)) begin
      pend_cnt <= pend_cnt - 2'd1;
    end
  end

  assign pend_done = (pend_cnt == 2'd0);
`else
  assign pend_done = 1'b1;
`endif

  always_ff @(posedge iClock) begin
    if (iReset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (overflow) state_next = ST_PENDING;
      end
      ST_PENDING: begin
        if (wr_tima)        state_next = ST_IDLE;
        else if (pend_done) state_next = ST_RELOAD;
      end
      ST_RELOAD: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    oTimerIrq = 1'b0;
    if (state == ST_RELOAD) oTimerIrq = 1'b1;
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      div      <= 16'h0000;
      tima     <= 8'h00;
      tma      <= 8'h00;
      tac      <= 3'b000;
      tap_hist <= 1'b0;
    end else begin
      div      <= wr_div ? 16'h0000 : div + 16'h0001;
      tap_hist <= tick_sig;
      if (wr_tma) tma <= iData;
      if (wr_tac) tac <= iData[2:0];
      // Reload beats CPU TIMA writes, but a TMA write in the same cycle feeds straight through.
      if (state == ST_RELOAD) begin
        tima <= wr_tma ? iData : tma;
      end else if (wr_tima) begin
        tima <= iData;
      end else if (tick) begin
        tima <= tima + 8'h01;
      end
    end
  end

  always_comb begin
    oData = 8'hFF;
    if (oSelected) begin
      case (iAddr[1:0])
        2'b00:   oData = div[15:8];
        2'b01:   oData = tima;
        2'b10:   oData = tma;
        default: oData = {5'b11111, tac};
      endcase
    end
  end

endmodule
